// File: rtl/word_pkg.sv
// Shared definitions for the word_bank storage block: sweep FSM states,
// lane-count helper and a parameter sanity check used at elaboration.
package word_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    function automatic int lanes_of(input int width, input int lane_width);
        return width / lane_width;
    endfunction

    function automatic bit cfg_ok(input int width, input int lane_width,
                                  input int depth, input int addr_width);
        if (lane_width <= 32'sd0) begin
            return 1'b0;
        end else begin
            return ((width % lane_width) == 32'sd0) && (depth >= 32'sd2) &&
                   (depth <= 32'sd256) && ((32'sd1 << addr_width) >= depth);
        end
    endfunction

endpackage

// File: rtl/word_row.sv
// One storage word with per-lane write enables and a synchronous preset strobe
// that takes priority over any lane write in the same cycle.
module word_row
    import word_pkg::*;
#(
    parameter int              Width     = 8,
    parameter int              LaneWidth = 8,
    parameter logic [Width-1:0] RST      = {Width{1'b0}},
    parameter logic [Width-1:0] PST      = {Width{1'b1}},
    localparam int             Lanes     = lanes_of(Width, LaneWidth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Lanes-1:0] lane_en,
    input  logic [Width-1:0] d,
    input  logic             pst,
    output logic [Width-1:0] q
);

    logic [Width-1:0] row_q;
    logic [Width-1:0] row_d;

    // Next word value: preset wins, otherwise merge enabled lanes.
    always_comb begin
        row_d = row_q;
        if (pst) begin
            row_d = PST;
        end else begin
            for (int i = 0; i < Lanes; i++) begin
                if (lane_en[i]) begin
                    row_d[i*LaneWidth +: LaneWidth] = d[i*LaneWidth +: LaneWidth];
                end else begin
                    row_d[i*LaneWidth +: LaneWidth] = row_q[i*LaneWidth +: LaneWidth];
                end
            end
        end
    end

    // Word storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= RST;
        end else begin
            row_q <= row_d;
        end
    end

    assign q = row_q;

endmodule

// File: rtl/word_bank.sv
// Multi-word register bank: lane-masked write port, two combinational read
// ports and an in-band preset engine that sweeps PST into every word in order.
module word_bank
    import word_pkg::*;
#(
    parameter int               Width     = 8,
    parameter int               LaneWidth = 8,
    parameter int               Depth     = 16,
    parameter int               AddrWidth = 4,
    parameter logic [Width-1:0] RST       = {Width{1'b0}},
    parameter logic [Width-1:0] PST       = {Width{1'b1}},
    localparam int              Lanes     = lanes_of(Width, LaneWidth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [Lanes-1:0]     wmask,
    input  logic [Width-1:0]     D,
    output logic                 wack,
    input  logic                 pst_req,
    output logic                 busy,
    input  logic [AddrWidth-1:0] raddr_a,
    output logic [Width-1:0]     Qa,
    input  logic [AddrWidth-1:0] raddr_b,
    output logic [Width-1:0]     Qb
);

    if (!cfg_ok(Width, LaneWidth, Depth, AddrWidth)) begin : g_cfg_err
        $error("word_bank: illegal Width/LaneWidth/Depth/AddrWidth combination");
    end

    localparam logic [AddrWidth:0]   DEPTH_V = (AddrWidth+1)'(Depth);
    localparam logic [AddrWidth-1:0] LAST    = AddrWidth'(Depth - 1);

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 pst_en_s;
    logic [AddrWidth-1:0] pst_idx_s;
    logic                 wack_s;
    logic [Width-1:0]     mem_s [Depth];

    assign wack_s = we && !busy_q && ({1'b0, waddr} < DEPTH_V);
    assign wack   = wack_s;
    assign busy   = busy_q;

    // Sweep sequencing: choose which word (if any) gets PST this edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        pst_en_s  = 1'b0;
        pst_idx_s = {AddrWidth{1'b0}};
        case (state_q)
            IDLE: begin
                if (pst_req) begin
                    state_d   = SWEEP;
                    pst_en_s  = 1'b1;
                    pst_idx_s = {AddrWidth{1'b0}};
                    cnt_d     = {{(AddrWidth-1){1'b0}}, 1'b1};
                    busy_d    = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            SWEEP: begin
                pst_en_s  = 1'b1;
                pst_idx_s = cnt_q;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = {AddrWidth{1'b0}};
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + {{(AddrWidth-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {AddrWidth{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM, sweep counter and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {AddrWidth{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar r = 0; r < Depth; r++) begin : g_row
        logic [Lanes-1:0] lane_en_s;
        logic             pst_s;

        assign lane_en_s = (wack_s && (waddr == AddrWidth'(r))) ? wmask : {Lanes{1'b0}};
        assign pst_s     = pst_en_s && (pst_idx_s == AddrWidth'(r));

        word_row #(
            .Width    (Width),
            .LaneWidth(LaneWidth),
            .RST      (RST),
            .PST      (PST)
        ) u_row (
            .clk    (clk),
            .rst    (rst),
            .lane_en(lane_en_s),
            .d      (D),
            .pst    (pst_s),
            .q      (mem_s[r])
        );
    end

    // Read muxes; addresses beyond Depth read as zero.
    always_comb begin
        Qa = {Width{1'b0}};
        Qb = {Width{1'b0}};
        if ({1'b0, raddr_a} < DEPTH_V) begin
            Qa = mem_s[raddr_a];
        end else begin
            Qa = {Width{1'b0}};
        end
        if ({1'b0, raddr_b} < DEPTH_V) begin
            Qb = mem_s[raddr_b];
        end else begin
            Qb = {Width{1'b0}};
        end
    end

endmodule

// File: tb/tb_word_bank.sv
// Self-checking bench for word_bank: directed table, multi-cycle sequences,
// and random traffic against a behavioural memory model.
`timescale 1ns/1ps
module tb_word_bank;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default configuration: 8x16.
    logic       we, pst_req, wack, busy;
    logic [3:0] waddr, raddr_a, raddr_b;
    logic [0:0] wmask;
    logic [7:0] d, qa, qb;

    // Wide configuration: 16-bit words, two lanes.
    logic        we16, pst16, wack16, busy16;
    logic [3:0]  waddr16, ra16, rb16;
    logic [1:0]  wmask16;
    logic [15:0] d16, qa16, qb16;

    // Non-power-of-two depth: 12 words.
    logic       we12, pst12, wack12, busy12;
    logic [3:0] waddr12, ra12, rb12;
    logic [0:0] wmask12;
    logic [7:0] d12, qa12, qb12;

    word_bank dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wmask(wmask), .D(d),
        .wack(wack), .pst_req(pst_req), .busy(busy),
        .raddr_a(raddr_a), .Qa(qa), .raddr_b(raddr_b), .Qb(qb)
    );

    word_bank #(.Width(16), .LaneWidth(8), .Depth(16), .AddrWidth(4)) dut16 (
        .clk(clk), .rst(rst), .we(we16), .waddr(waddr16), .wmask(wmask16), .D(d16),
        .wack(wack16), .pst_req(pst16), .busy(busy16),
        .raddr_a(ra16), .Qa(qa16), .raddr_b(rb16), .Qb(qb16)
    );

    word_bank #(.Width(8), .LaneWidth(8), .Depth(12), .AddrWidth(4)) dut12 (
        .clk(clk), .rst(rst), .we(we12), .waddr(waddr12), .wmask(wmask12), .D(d12),
        .wack(wack12), .pst_req(pst12), .busy(busy12),
        .raddr_a(ra12), .Qa(qa12), .raddr_b(rb12), .Qb(qb12)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic       m;
        logic [7:0] d;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       ewack;
        logic [7:0] eqa;
        logic [7:0] eqb;
    } vec_t;

    vec_t tbl[7];

    // Behavioural reference for random phase.
    logic [7:0] m_mem [16];
    int         m_pos;
    bit         m_busy;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic ew;

        tbl[0] = '{1'b1, 4'd7,  1'b1, 8'h5A, 4'd7,  4'd7,  1'b1, 8'h00, 8'h00};
        tbl[1] = '{1'b0, 4'd0,  1'b0, 8'h00, 4'd7,  4'd0,  1'b0, 8'h5A, 8'h00};
        tbl[2] = '{1'b1, 4'd3,  1'b0, 8'hFF, 4'd3,  4'd7,  1'b1, 8'h00, 8'h5A};
        tbl[3] = '{1'b1, 4'd3,  1'b1, 8'h3C, 4'd3,  4'd7,  1'b1, 8'h00, 8'h5A};
        tbl[4] = '{1'b0, 4'd0,  1'b0, 8'h00, 4'd3,  4'd15, 1'b0, 8'h3C, 8'h00};
        tbl[5] = '{1'b1, 4'd15, 1'b1, 8'h81, 4'd15, 4'd3,  1'b1, 8'h00, 8'h3C};
        tbl[6] = '{1'b0, 4'd0,  1'b0, 8'h00, 4'd15, 4'd3,  1'b0, 8'h81, 8'h3C};

        we = 1'b0; waddr = 4'd0; wmask = 1'b0; d = 8'h00; pst_req = 1'b0;
        raddr_a = 4'd0; raddr_b = 4'd0;
        we16 = 1'b0; waddr16 = 4'd0; wmask16 = 2'b00; d16 = 16'h0000; pst16 = 1'b0;
        ra16 = 4'd0; rb16 = 4'd0;
        we12 = 1'b0; waddr12 = 4'd0; wmask12 = 1'b0; d12 = 8'h00; pst12 = 1'b0;
        ra12 = 4'd0; rb12 = 4'd0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset defaults on both ports.
        for (int i = 0; i < 16; i++) begin
            raddr_a = 4'(i); raddr_b = 4'(15 - i);
            #1;
            chk("reset_qa", 32'(qa), 32'h0);
            chk("reset_qb", 32'(qb), 32'h0);
        end
        chk("reset_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;

        // Directed table: outputs checked before the committing edge.
        for (int i = 0; i < 7; i++) begin
            we = tbl[i].we; waddr = tbl[i].wa; wmask = tbl[i].m; d = tbl[i].d;
            raddr_a = tbl[i].ra; raddr_b = tbl[i].rb;
            @(negedge clk);
            chk("tbl_wack", 32'(wack), 32'(tbl[i].ewack));
            chk("tbl_qa",   32'(qa),   32'(tbl[i].eqa));
            chk("tbl_qb",   32'(qb),   32'(tbl[i].eqb));
            chk("tbl_busy", 32'(busy), 32'h0);
            @(posedge clk); #1;
        end
        we = 1'b0;

        // Sweep: one-cycle pulse, mid-sweep write rejected.
        pst_req = 1'b1;
        @(posedge clk); #1;
        pst_req = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            we = (c == 2); waddr = 4'd2; wmask = 1'b1; d = 8'h00;
            raddr_a = 4'd15; raddr_b = 4'd0;
            @(negedge clk);
            if (c == 0) begin
                chk("sweep_old_read", 32'(qa), 32'h81);
                chk("sweep_word0",    32'(qb), 32'hFF);
            end
            if (c == 2) chk("sweep_wack", 32'(wack), 32'h0);
            if (!busy) break;
            n++;
            @(posedge clk); #1;
        end
        we = 1'b0;
        chk("sweep_busy_len", 32'(n), 32'd15);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            raddr_a = 4'(i); raddr_b = 4'(i);
            #1;
            chk("sweep_final", 32'(qa), 32'hFF);
        end

        // Reset in the middle of a sweep is immediate and complete.
        pst_req = 1'b1;
        @(posedge clk); #1;
        pst_req = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            raddr_a = 4'(i); raddr_b = 4'(i);
            #0.1;
            chk("midrst_qa", 32'(qa), 32'h0);
        end
        chk("midrst_busy", 32'(busy), 32'h0);
        #0.3 rst = 1'b0;
        @(posedge clk); #1;
        we = 1'b1; waddr = 4'd9; wmask = 1'b1; d = 8'hC3;
        @(negedge clk);
        chk("postrst_wack", 32'(wack), 32'h1);
        @(posedge clk); #1;
        we = 1'b0; raddr_a = 4'd9;
        @(negedge clk);
        chk("postrst_read", 32'(qa), 32'hC3);
        @(posedge clk); #1;

        // Lane masks on the 16-bit bank.
        we16 = 1'b1; waddr16 = 4'd3; wmask16 = 2'b11; d16 = 16'hA5C3; ra16 = 4'd3;
        @(negedge clk);
        chk("lane_wack1", 32'(wack16), 32'h1);
        @(posedge clk); #1;
        wmask16 = 2'b01; d16 = 16'hFF00;
        @(negedge clk);
        chk("lane_wack2", 32'(wack16), 32'h1);
        chk("lane_mid", 32'(qa16), 32'hA5C3);
        @(posedge clk); #1;
        we16 = 1'b0;
        @(negedge clk);
        chk("lane_final", 32'(qa16), 32'hA500);
        @(posedge clk); #1;

        // Depth=12: range rejection and short sweep.
        we12 = 1'b1; waddr12 = 4'd13; wmask12 = 1'b1; d12 = 8'h77;
        ra12 = 4'd13; rb12 = 4'd11;
        @(negedge clk);
        chk("range_wack", 32'(wack12), 32'h0);
        @(posedge clk); #1;
        waddr12 = 4'd11; d12 = 8'h33;
        @(negedge clk);
        chk("range_read13", 32'(qa12), 32'h0);
        chk("range_wack11", 32'(wack12), 32'h1);
        @(posedge clk); #1;
        we12 = 1'b0;
        @(negedge clk);
        chk("range_read11", 32'(qb12), 32'h33);
        chk("range_read13b", 32'(qa12), 32'h0);
        @(posedge clk); #1;
        pst12 = 1'b1;
        @(posedge clk); #1;
        pst12 = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy12) break;
            n++;
            @(posedge clk); #1;
        end
        chk("d12_busy_len", 32'(n), 32'd11);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            ra12 = 4'(i);
            #1;
            chk("d12_final", 32'(qa12), (i < 12) ? 32'hFF : 32'h0);
        end

        // Random traffic against the behavioural model, from a fresh reset.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_pos = 0; m_busy = 1'b0;
        for (int c = 0; c < 400; c++) begin
            we = 1'($urandom_range(0, 1)); waddr = 4'($urandom); wmask = 1'($urandom);
            d = 8'($urandom); pst_req = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) raddr_a = waddr; else raddr_a = 4'($urandom);
            raddr_b = 4'($urandom);
            @(negedge clk);
            ew = we && !m_busy;
            chk("rnd_wack", 32'(wack), 32'(ew));
            chk("rnd_busy", 32'(busy), 32'(m_busy));
            chk("rnd_qa",   32'(qa),   32'(m_mem[raddr_a]));
            chk("rnd_qb",   32'(qb),   32'(m_mem[raddr_b]));
            if (ew && wmask[0]) m_mem[waddr] = d;
            if (m_busy) begin
                m_mem[m_pos] = 8'hFF;
                m_pos++;
                if (m_pos == 16) m_busy = 1'b0;
            end else if (pst_req) begin
                m_mem[0] = 8'hFF;
                m_pos = 1;
                m_busy = 1'b1;
            end
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/word_bank.md
Name: word_bank

Overview:
- Parametrised multi-word storage bank. Holds Depth words of Width bits, with one lane-masked write port and two combinational read ports.
- Preset is an in-band, one-word-per-cycle sweep engine with a busy handshake. It is not an asynchronous pin.
- Used by the genetic-hardware datapath as the general register/genome store that replaces banks of hand-instantiated single words.

Parameters:
- Width, 8, bits per word; must be a multiple of LaneWidth.
- LaneWidth, 8, bits per write-mask lane; Lanes = Width/LaneWidth.
- Depth, 16, number of words; 2..256.
- AddrWidth, 4, address bits; must satisfy 2**AddrWidth >= Depth.
- RST, {Width{1'b0}}, value of every word after asynchronous reset.
- PST, {Width{1'b1}}, value written to every word by a preset sweep.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write request.
- waddr  input  AddrWidth  write address.
- wmask  input  Lanes  per-lane write enable; bit i covers D[i*LaneWidth +: LaneWidth].
- D  input  Width  write data.
- wack  output  1  combinational; high when the write is accepted this cycle.
- pst_req  input  1  start a preset sweep (level sampled on clk).
- busy  output  1  registered; high while the sweep is running.
- raddr_a  input  AddrWidth  read address, port A.
- Qa  output  Width  combinational read data, port A.
- raddr_b  input  AddrWidth  read address, port B.
- Qb  output  Width  combinational read data, port B.

Behaviour:
- Clocking and reset: one clock domain, clk; reset is asynchronous and active-high (rst).
- Reset (rst high, async):
  - All words = RST.
  - FSM = IDLE; sweep counter = 0; busy = 0.
  - Reset overrides everything, including mid-sweep; no partial preset survives.
- Reads:
  - Qa = mem[raddr_a], Qb = mem[raddr_b], both combinational from stored state.
  - Reading the address being written in the same cycle returns the old value; the new value is visible the cycle after the edge.
  - Out-of-range address (>= Depth) reads {Width{1'b0}}.
- Write acceptance:
  - wack = we & ~busy & (waddr < Depth).
  - On an accepted write, only lanes with wmask[i]=1 update; other lanes hold.
  - wmask = 0 with wack = 1 is a legal no-op.
  - A rejected write has no effect and is not queued; the requester must retry.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP: on an edge with pst_req = 1. In that same edge, word 0 = PST, counter = 1, busy = 1.
  - If an accepted write and the sweep start coincide, the write commits first and is then overwritten only if it targets word 0. Because it is in-range and accepted, its other addresses keep D.
  - SWEEP: each edge writes word[counter] = PST and increments counter.
  - When counter == Depth-1, that edge writes the last word, returns to IDLE, and clears busy.
  - A full sweep takes Depth cycles; busy is high for Depth-1 cycles after the start edge (Depth=16: start edge plus 15 busy cycles).
  - pst_req during SWEEP is ignored.
  - pst_req held high in IDLE immediately after completion restarts the sweep.
- Preset order: ascending addresses. A read of address k during the sweep returns PST once k has been swept, otherwise the old value.
- Width rule: the counter is AddrWidth bits. The terminal compare is against Depth-1, so non-power-of-two Depth never touches unused indices.

Decomposition:
- Shared package word_pkg:
  - FSM state typedef (IDLE=1'b0, SWEEP=1'b1).
  - Lanes localparam function.
  - Elaboration checks: Width % LaneWidth == 0 and 2**AddrWidth >= Depth; fail elaboration otherwise.
- Sub-module word_row: one Width-bit row with async rst to RST.
  - Inputs: lane enable vector, data, sync preset strobe; preset has priority over lane write.
  - Instantiated Depth times via generate.
- The top level holds the FSM, counter, address decode, and read muxes.

Test Plan:
- Reset defaults: rst pulse, then read all 16 addresses on both ports -> every Qa/Qb = 8'h00; busy = 0.
- Lane mask, Width=16, LaneWidth=8: write 16'hA5C3 to addr 3 with wmask=2'b11, then 16'hFF00 with wmask=2'b01 -> Qa(3) = 16'hA500; wack = 1 both cycles.
- Same-cycle read/write: write 8'h5A to addr 7 while raddr_b=7 -> Qb shows the old value that cycle and 8'h5A the next cycle.
- Sweep timing:
  - pst_req one-cycle pulse -> busy high for exactly 15 cycles after the start edge; all words = 8'hFF afterwards.
  - A write to addr 2 issued mid-sweep -> wack = 0 and addr 2 stays 8'hFF.
- Reset mid-sweep: rst asserted 5 cycles into the sweep -> all words = 8'h00 immediately (async, without a clock edge); busy = 0; a subsequent write to addr 9 is accepted.
- Range and Depth=12 sweep: write to waddr=13 with Depth=12 -> wack = 0 and read of 13 = 0. A sweep with Depth=12 -> busy high for 11 cycles after the start edge; words 0..11 = PST.
